// File: rtl/cordic_sqrt_arbiter.sv
// Round-robin arbiter sharing one fixed-latency CORDIC square-root core among
// N_REQ requesters. A tag FIFO records the issuing requester of every
// in-flight operation so results are routed back in issue order.
module cordic_sqrt_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DIN_W        = 16,
  parameter int unsigned DOUT_W       = 16,
  parameter int unsigned LATENCY      = 20,
  parameter int unsigned MAX_INFLIGHT = 8
) (
  input  logic                   aclk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*DIN_W-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [DOUT_W-1:0]      rsp_data,
  output logic                   s_axis_cartesian_tvalid,
  output logic [DIN_W-1:0]       s_axis_cartesian_tdata,
  input  logic                   m_axis_dout_tvalid,
  input  logic [DOUT_W-1:0]      m_axis_dout_tdata,
  output logic                   busy,
  output logic                   err_orphan
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned AW    = $clog2(MAX_INFLIGHT);
  localparam int unsigned CNT_W = AW + 1;
  localparam int unsigned FL_W  = $clog2(LATENCY + 3);

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t             r_state;
  logic [FL_W-1:0]    r_flush_cnt;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_tags [MAX_INFLIGHT];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_tvalid;
  logic [DIN_W-1:0]   r_tdata;
  logic [N_REQ-1:0]   r_rsp_valid;
  logic [DOUT_W-1:0]  r_rsp_data;
  logic               r_busy;
  logic               r_err_orphan;

  logic               w_run;
  logic               w_pop;
  logic               w_orphan;
  logic               w_credit;
  logic               w_grant_vld;
  logic [PTR_W-1:0]   w_grant_idx;
  logic               w_hs;
  logic [DIN_W-1:0]   w_operand;
  logic [PTR_W-1:0]   w_head;
  logic [CNT_W-1:0]   w_count_nxt;

  // Requester index p+k modulo N_REQ
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p,
                                                 input int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return PTR_W'(s);
  endfunction

  assign w_run    = (r_state == ST_RUN);
  assign w_head   = r_tags[r_rd_ptr];
  assign w_pop    = w_run & m_axis_dout_tvalid & (r_count != '0);
  assign w_orphan = w_run & m_axis_dout_tvalid & (r_count == '0);
  // A pop in the same cycle frees the slot the new issue will occupy
  assign w_credit = w_run & ((r_count < CNT_W'(MAX_INFLIGHT)) | w_pop);
  assign w_hs     = w_grant_vld & w_credit;

  // First valid requester at or after rr_ptr; scanning downward so the lowest offset wins
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int unsigned k = N_REQ; k > 0; k--) begin
      if (req_valid[wrap_add(r_rr_ptr, k - 1)]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = wrap_add(r_rr_ptr, k - 1);
      end
    end
  end

  // One-hot accept and operand mux for the granted requester
  always_comb begin
    req_ready = '0;
    w_operand = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_grant_idx == PTR_W'(i)) begin
        req_ready[i] = w_hs;
        w_operand    = req_data[i*DIN_W +: DIN_W];
      end
    end
  end

  // In-flight count after this cycle's push/pop
  always_comb begin
    w_count_nxt = r_count;
    case ({w_hs, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Tag storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge aclk) begin
    if (w_hs) r_tags[r_wr_ptr] <= w_grant_idx;
  end

  // Control FSM, FIFO pointers, core drive and response routing
  always_ff @(posedge aclk) begin
    if (rst) begin
      r_state      <= ST_FLUSH;
      r_flush_cnt  <= '0;
      r_rr_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_tvalid     <= 1'b0;
      r_tdata      <= '0;
      r_rsp_valid  <= '0;
      r_rsp_data   <= '0;
      r_busy       <= 1'b0;
      r_err_orphan <= 1'b0;
    end else begin
      r_tvalid <= w_hs;
      if (w_hs) begin
        r_tdata  <= w_operand;
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_rr_ptr <= (w_grant_idx == PTR_W'(N_REQ - 1)) ? '0 : w_grant_idx + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + AW'(1);
        r_rsp_data <= m_axis_dout_tdata;
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
        r_rsp_valid[i] <= w_pop && (w_head == PTR_W'(i));
      end
      r_count <= w_count_nxt;
      r_busy  <= (w_count_nxt != '0);
      if (w_orphan) r_err_orphan <= 1'b1;
      case (r_state)
        ST_FLUSH: begin
          // Stale core results from before reset drain out during these cycles
          if (r_flush_cnt == FL_W'(LATENCY + 1)) r_state <= ST_RUN;
          else r_flush_cnt <= r_flush_cnt + FL_W'(1);
        end
        ST_RUN:  r_state <= ST_RUN;
        default: r_state <= ST_FLUSH;
      endcase
    end
  end

  assign rsp_valid               = r_rsp_valid;
  assign rsp_data                = r_rsp_data;
  assign s_axis_cartesian_tvalid = r_tvalid;
  assign s_axis_cartesian_tdata  = r_tdata;
  assign busy                    = r_busy;
  assign err_orphan              = r_err_orphan;

endmodule

// File: tb/tb_cordic_sqrt_arbiter.sv
// Bench for cordic_sqrt_arbiter: a behavioural fixed-latency sqrt core,
// directed stimulus with hand-computed results, and a scoreboard monitor.
module tb_cordic_sqrt_arbiter;

  localparam int N    = 4;
  localparam int L    = 20;
  localparam int MAXF = 8;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*16-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  rsp_valid;
  logic [15:0]   rsp_data;
  logic          tvalid;
  logic [15:0]   tdata;
  logic          dout_tvalid;
  logic [15:0]   dout_tdata;
  logic          busy;
  logic          err_orphan;

  cordic_sqrt_arbiter #(
    .N_REQ(N), .DIN_W(16), .DOUT_W(16), .LATENCY(L), .MAX_INFLIGHT(MAXF)
  ) dut (
    .aclk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .s_axis_cartesian_tvalid(tvalid), .s_axis_cartesian_tdata(tdata),
    .m_axis_dout_tvalid(dout_tvalid), .m_axis_dout_tdata(dout_tdata),
    .busy(busy), .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  logic   mon_en = 1'b0;
  logic   force_orphan = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural core: unsigned integer sqrt, fixed latency, no reset
  function automatic logic [15:0] isqrt(input logic [15:0] x);
    int unsigned r = 0;
    while ((r + 1) * (r + 1) <= 32'(x)) r++;
    return 16'(r);
  endfunction

  logic        core_v [L];
  logic [15:0] core_d [L];
  initial for (int i = 0; i < L; i++) begin core_v[i] = 1'b0; core_d[i] = '0; end

  always @(posedge clk) begin
    core_v[0] <= tvalid;
    core_d[0] <= isqrt(tdata);
    for (int i = 1; i < L; i++) begin
      core_v[i] <= core_v[i-1];
      core_d[i] <= core_d[i-1];
    end
  end

  assign dout_tvalid = core_v[L-1] | force_orphan;
  assign dout_tdata  = force_orphan ? 16'h0055 : core_d[L-1];

  // Scoreboard of expected responses
  typedef struct {
    int          idx;
    logic [15:0] data;
    longint      when;
  } exp_t;
  exp_t        sbq[$];
  logic [15:0] cur_exp [N];
  logic        prev_hs = 1'b0;
  logic [15:0] prev_data = '0;

  // Handshake watcher: pushes expectations and checks the core-side issue
  always @(negedge clk) begin
    if (mon_en) begin
      chk("s_axis_tvalid", 64'(tvalid), 64'(prev_hs));
      if (prev_hs) chk("s_axis_tdata", 64'(tdata), 64'(prev_data));
      prev_hs = 1'b0;
      if (rst) begin
        sbq.delete();
      end else begin
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && req_ready[i] && !prev_hs) begin
            exp_t e;
            prev_hs   = 1'b1;
            prev_data = req_data[i*16 +: 16];
            e.idx  = i;
            e.data = cur_exp[i];
            e.when = cyc + L + 2;
            sbq.push_back(e);
          end
        end
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (mon_en && rsp_valid != '0) begin
      if (sbq.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(1) << e.idx);
        chk("rsp_data", 64'(rsp_data), 64'(e.data));
        chk("rsp_latency", 64'(cyc), 64'(e.when));
      end
    end
  end

  // At most one accept per cycle
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      assert ($onehot0(req_ready)) else begin
        failures++;
        $display("FAIL ready_onehot actual=%b required=onehot0", req_ready);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic set_req(input int i, input logic [15:0] d, input logic [15:0] e);
    req_data[i*16 +: 16] = d;
    cur_exp[i] = e;
  endtask

  // Pulse reset, hold one request and measure the FLUSH length until it is accepted
  task automatic reset_and_issue(input int r, input logic [15:0] d, input logic [15:0] e);
    int n = 0;
    logic got = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(r, d, e);
    req_valid = N'(1) << r;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (req_ready[r]) got = 1'b1;
      else n++;
    end
    chk("flush_len", 64'(n), 64'(L + 2));
    chk("flush_grant", 64'(got), 64'(1));
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_remaining", 64'(sbq.size()), 64'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  logic [3:0] t6_valid [7];
  logic [3:0] t6_ready [7];
  logic [49:0] t3_seen;
  logic [49:0] t3_exp;

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) cur_exp[i] = '0;

    // Reset values
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'(0));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_rsp_data", 64'(rsp_data), 64'(0));
    chk("reset_tdata", 64'(tdata), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_err_orphan", 64'(err_orphan), 64'(0));

    // 1: single request after FLUSH, 0x24 -> 6
    reset_and_issue(0, 16'h0024, 16'h0006);
    drain();

    // Prep: one issue from requester 3 so rr_ptr returns to 0
    reset_and_issue(3, 16'd9, 16'd3);
    drain();

    // 2: all four requesters continuously valid
    set_req(0, 16'd16, 16'd4);
    set_req(1, 16'd25, 16'd5);
    set_req(2, 16'd49, 16'd7);
    set_req(3, 16'd81, 16'd9);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_grant", 64'(req_ready), 64'(1) << (k % 4));
      @(posedge clk); #1;
    end
    req_valid = '0;
    drain();

    // 3: credit limit, requester 2 always valid
    set_req(2, 16'd144, 16'd12);
    req_valid = 4'b0100;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      t3_seen[c] = req_ready[2];
      t3_exp[c]  = (c < 8) || (c >= 21 && c <= 28) || (c >= 42);
      if (c == 30) chk("credit_busy", 64'(busy), 64'(1));
      @(posedge clk); #1;
    end
    req_valid = '0;
    chk("credit_ready_pattern", 64'(t3_seen), 64'(t3_exp));
    drain();
    chk("idle_busy", 64'(busy), 64'(0));

    // 5: orphan result with empty tag FIFO
    @(posedge clk); #1;
    force_orphan = 1'b1;
    @(posedge clk); #1;
    force_orphan = 1'b0;
    @(negedge clk);
    chk("orphan_set", 64'(err_orphan), 64'(1));
    @(posedge clk); #1;
    set_req(0, 16'd64, 16'd8);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("post_orphan_grant", 64'(req_ready), 64'(4'b0001));
    @(posedge clk); #1;
    req_valid = '0;
    drain();
    chk("orphan_sticky", 64'(err_orphan), 64'(1));

    // 6: round-robin with a dropping requester (rr_ptr starts at 1)
    set_req(0, 16'd4, 16'd2);
    set_req(1, 16'd1, 16'd1);
    set_req(2, 16'd0, 16'd0);
    set_req(3, 16'hFFFF, 16'd255);
    t6_valid = '{4'b1000, 4'b0011, 4'b1010, 4'b1000, 4'b0101, 4'b0100, 4'b0011};
    t6_ready = '{4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0100, 4'b0001};
    for (int k = 0; k < 7; k++) begin
      req_valid = t6_valid[k];
      @(negedge clk);
      chk("rr_drop_grant", 64'(req_ready), 64'(t6_ready[k]));
      @(posedge clk); #1;
    end
    req_valid = '0;
    drain();

    // 4: reset with five operations in flight
    set_req(0, 16'd36, 16'd6);
    req_valid = 4'b0001;
    repeat (5) begin
      @(posedge clk); #1;
    end
    req_valid = '0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("inflight_busy", 64'(busy), 64'(1));
    reset_and_issue(1, 16'd100, 16'd10);
    chk("err_after_reset", 64'(err_orphan), 64'(0));
    drain();
    chk("err_after_flush", 64'(err_orphan), 64'(0));
    chk("final_busy", 64'(busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
